// File: rtl/fa16_rev_pkg.sv
// Shared types and constants for the fa16 reversible-macro controller.
// Result bundle positions mirror the operand bundle (s/a, a_b/b, c0_b/c0, c15/z).
package fa16_rev_pkg;

   localparam int unsigned SETTLE_CYC_DEF = 4;

   localparam int unsigned A_LSB  = 0;
   localparam int unsigned B_LSB  = A_LSB + 16;
   localparam int unsigned C0_BIT = B_LSB + 16;
   localparam int unsigned Z_BIT  = C0_BIT + 1;
   localparam int unsigned OPW    = Z_BIT + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FWD,
      ST_RESP,
      ST_TURN,
      ST_BWD
   } state_t;

endpackage

// File: rtl/fa16_rail_chk.sv
// Combinational dual-rail checker: flags any bit whose complement rail
// does not carry the inverse of its true rail.
module fa16_rail_chk
   import fa16_rev_pkg::*;
(
   input  logic [OPW-1:0] rail_t,
   input  logic [OPW-1:0] rail_f,
   output logic           rail_err
);

   always_comb begin
      rail_err = |(rail_t ~^ rail_f);
   end

endmodule

// File: rtl/fa16_rev_ctrl.sv
// Controller sequencing a reversible 16-bit macro: forward evaluation,
// response handshake and an optional backward (uncompute) pass.
module fa16_rev_ctrl
   import fa16_rev_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [OPW-1:0] req_data,
   input  logic           req_uncomp,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [OPW-1:0] rsp_data,
   output logic           rsp_err,
   output logic           unc_done,
   output logic           unc_ok,
   output logic           dir,
   output logic [OPW-1:0] fside_o,
   output logic [OPW-1:0] fside_not_o,
   output logic           fside_oe,
   input  logic [OPW-1:0] fside_i,
   input  logic [OPW-1:0] fside_not_i,
   output logic [OPW-1:0] rside_o,
   output logic [OPW-1:0] rside_not_o,
   output logic           rside_oe,
   input  logic [OPW-1:0] rside_i,
   input  logic [OPW-1:0] rside_not_i
);

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

   state_t         state_q, state_d;
   logic [7:0]     cnt_q;
   logic [OPW-1:0] op_q, res_q;
   logic           unc_q, err_q, done_q, ok_q;
   logic           cnt_zero, chk_err;
   logic [OPW-1:0] chk_t, chk_f;

   assign cnt_zero = (cnt_q == '0);

   // One checker serves both directions: the sampled side follows dir.
   assign chk_t = (state_q == ST_BWD) ? fside_i     : rside_i;
   assign chk_f = (state_q == ST_BWD) ? fside_not_i : rside_not_i;

   fa16_rail_chk u_rail_chk (
      .rail_t   (chk_t),
      .rail_f   (chk_f),
      .rail_err (chk_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      dir         = 1'b0;
      fside_oe    = 1'b0;
      rside_oe    = 1'b0;
      fside_o     = '0;
      fside_not_o = '0;
      rside_o     = '0;
      rside_not_o = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ST_FWD;
         end
         ST_FWD: begin
            fside_oe    = 1'b1;
            fside_o     = op_q;
            fside_not_o = ~op_q;
            if (cnt_zero) state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = unc_q ? ST_TURN : ST_IDLE;
         end
         ST_TURN: begin
            dir     = 1'b1;
            state_d = ST_BWD;
         end
         ST_BWD: begin
            dir         = 1'b1;
            rside_oe    = 1'b1;
            rside_o     = res_q;
            rside_not_o = ~res_q;
            if (cnt_zero) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         op_q   <= '0;
         res_q  <= '0;
         unc_q  <= 1'b0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         ok_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ok_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q  <= req_data;
                  unc_q <= req_uncomp;
                  err_q <= 1'b0;
                  cnt_q <= CNT_LOAD;
               end
            end
            ST_FWD: begin
               if (cnt_zero) begin
                  res_q <= rside_i;
                  err_q <= chk_err;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_TURN: cnt_q <= CNT_LOAD;
            ST_BWD: begin
               if (cnt_zero) begin
                  done_q <= 1'b1;
                  ok_q   <= ~chk_err & (fside_i == op_q);
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_data = res_q;
   assign rsp_err  = err_q;
   assign unc_done = done_q;
   assign unc_ok   = ok_q;

endmodule
